// File: rtl/rf_pkg.sv
// Shared register-file constants and the write-request record used by the
// writeback arbiter.
package rf_pkg;

  localparam int RF_ADDR_W = 5;
  localparam int RF_DATA_W = 32;

  // One register-file write: destination and value.
  typedef struct packed {
    logic [RF_ADDR_W-1:0] addr;
    logic [RF_DATA_W-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/rf_write_arbiter_rr_arb2.sv
// Two-way grant between writeback sources A and B. Round-robin on the
// remembered last winner, or A-always-wins when FIXED_PRIO is set.
module rr_arb2 #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic a_valid,
  input  logic b_valid,
  output logic a_grant,
  output logic b_grant,
  output logic last_grant
);

  logic last_q;

  assign last_grant = last_q;

  // Grant decode: a lone requester wins; on contention the source that did
  // not win last time goes next. Nothing is granted while in reset.
  always_comb begin
    a_grant = 1'b0;
    b_grant = 1'b0;
    if (!rst) begin
      if (a_valid && b_valid) begin
        if (FIXED_PRIO || last_q) a_grant = 1'b1;
        else                      b_grant = 1'b1;
      end else begin
        a_grant = a_valid;
        b_grant = b_valid;
      end
    end
  end

  // Remember the last winner; a grant always means an accept, because a
  // source is only granted while it is valid. Reset favours A first.
  always_ff @(posedge clk) begin
    if (rst)          last_q <= 1'b1;
    else if (a_grant) last_q <= 1'b0;
    else if (b_grant) last_q <= 1'b1;
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: picks one of two writeback sources per
// cycle, registers the winner into a single write stage that drives the
// register file, and offers bypass compares against that in-flight write.
//
// Handshake: a source presents addr/data with valid held high; the write is
// taken in the cycle where valid and ready are both high. ready never
// depends on anything but the valids and the arbiter state, and a losing
// source must keep valid, addr and data stable until it is accepted.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W      = RF_DATA_W,
  parameter int ADDR_W      = RF_ADDR_W,
  parameter bit ZERO_REG_RO = 1'b1,
  parameter bit FIXED_PRIO  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              reg_write_en,
  output logic [ADDR_W-1:0] reg_write_addr,
  output logic [DATA_W-1:0] reg_write_data,
  input  logic [ADDR_W-1:0] byp_addr_1,
  output logic              byp_hit_1,
  input  logic [ADDR_W-1:0] byp_addr_2,
  output logic              byp_hit_2,
  output logic [DATA_W-1:0] byp_data,
  output logic              last_grant
);

  logic              a_acc;
  logic              b_acc;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              sel_drop;

  rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
    .clk        (clk),
    .rst        (rst),
    .a_valid    (a_valid),
    .b_valid    (b_valid),
    .a_grant    (a_ready),
    .b_grant    (b_ready),
    .last_grant (last_grant)
  );

  assign a_acc = a_valid & a_ready;
  assign b_acc = b_valid & b_ready;

  // Steer the accepted source into the stage; register 0 writes are
  // swallowed when it is hard-wired read-only.
  always_comb begin
    sel_addr = b_addr;
    sel_data = b_data;
    if (a_acc) begin
      sel_addr = a_addr;
      sel_data = a_data;
    end
    sel_drop = ZERO_REG_RO && (sel_addr == '0);
  end

  // Write stage: one enable pulse per accept; addr/data hold when idle.
  // Reset discards whatever was staged.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_en   <= 1'b0;
      reg_write_addr <= '0;
      reg_write_data <= '0;
    end else if (a_acc || b_acc) begin
      reg_write_en   <= !sel_drop;
      reg_write_addr <= sel_addr;
      reg_write_data <= sel_data;
    end else begin
      reg_write_en   <= 1'b0;
    end
  end

  // Bypass: forward the write the register file is about to commit.
  always_comb begin
    byp_hit_1 = reg_write_en && (byp_addr_1 == reg_write_addr);
    byp_hit_2 = reg_write_en && (byp_addr_2 == reg_write_addr);
    byp_data  = reg_write_data;
  end

endmodule
